// File: rtl/fpu_arith_sequencer.sv
// Sequences one shared FPU arithmetic unit: request latch, enable pulse, watchdog wait, 1-2 writeback beats.
// Optional performance counters are compiled in with FPU_SEQ_PERF_EN.
module fpu_arith_sequencer #(
  parameter int TIMEOUT_CYCLES = 1023
`ifdef FPU_SEQ_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [3:0]    req_op,
  input  logic [1:0]    req_rmode,
  input  logic [79:0]   req_a,
  input  logic [79:0]   req_b,
  output logic [3:0]    au_operation,
  output logic          au_enable,
  output logic [1:0]    au_rounding_mode,
  output logic [79:0]   au_operand_a,
  output logic [79:0]   au_operand_b,
  output logic [15:0]   au_int16_in,
  output logic [31:0]   au_int32_in,
  output logic [31:0]   au_fp32_in,
  output logic [63:0]   au_fp64_in,
  input  logic [79:0]   au_result,
  input  logic [79:0]   au_result_secondary,
  input  logic          au_has_secondary,
  input  logic [15:0]   au_int16_out,
  input  logic [31:0]   au_int32_out,
  input  logic [31:0]   au_fp32_out,
  input  logic [63:0]   au_fp64_out,
  input  logic          au_done,
  input  logic [3:0]    au_cc,
  input  logic [5:0]    au_flags,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic [79:0]   wb_data,
  output logic          wb_secondary,
  output logic          wb_last,
  output logic [3:0]    wb_cc,
  output logic [5:0]    wb_flags,
  output logic          wb_timeout,
  output logic          busy
`ifdef FPU_SEQ_PERF_EN
  , output logic [CNT_W-1:0] perf_ops
  , output logic [CNT_W-1:0] perf_busy_cycles
  , output logic [CNT_W-1:0] perf_timeouts
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_WB_PRI = 3'd3,
    ST_WB_SEC = 3'd4
  } state_t;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t        state_r, state_nxt_s;
  logic          done_take_s, to_take_s;
  logic [3:0]    op_r;
  logic [1:0]    rmode_r;
  logic [79:0]   a_r, b_r;
  logic          en_r;
  logic [15:0]   wd_cnt_r;
  logic          has_sec_r;
  logic [79:0]   sec_data_r;
  logic          wb_valid_r, wb_sec_r, wb_last_r, wb_to_r, busy_r, req_ready_r;
  logic [79:0]   wb_data_r;
  logic [3:0]    wb_cc_r;
  logic [5:0]    wb_flags_r;

  // Integer/narrow-float results are raw bit patterns, zero-extended into the 80-bit beat.
  function automatic logic [79:0] fmt_primary(input logic [3:0] op, input logic [79:0] res,
                                              input logic [15:0] i16, input logic [31:0] i32,
                                              input logic [31:0] f32, input logic [63:0] f64);
    case (op)
      4'd6:    fmt_primary = {64'd0, i16};
      4'd7:    fmt_primary = {48'd0, i32};
      4'd10:   fmt_primary = {48'd0, f32};
      4'd11:   fmt_primary = {16'd0, f64};
      default: fmt_primary = res;
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next-state logic; done wins over a watchdog expiry in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    done_take_s = 1'b0;
    to_take_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) state_nxt_s = ST_ISSUE;
        else           state_nxt_s = ST_IDLE;
      end
      ST_ISSUE: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (au_done) begin
          done_take_s = 1'b1;
          state_nxt_s = ST_WB_PRI;
        end else if (wd_cnt_r == WD_LAST) begin
          to_take_s   = 1'b1;
          state_nxt_s = ST_WB_PRI;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_WB_PRI: begin
        if (wb_ready) state_nxt_s = has_sec_r ? ST_WB_SEC : ST_IDLE;
        else          state_nxt_s = ST_WB_PRI;
      end
      ST_WB_SEC: begin
        if (wb_ready) state_nxt_s = ST_IDLE;
        else          state_nxt_s = ST_WB_SEC;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Holding registers, watchdog, capture and writeback beat registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r <= 4'd0;  rmode_r <= 2'd0;  a_r <= 80'd0;  b_r <= 80'd0;
      en_r <= 1'b0;  wd_cnt_r <= 16'd0;  has_sec_r <= 1'b0;  sec_data_r <= 80'd0;
      wb_valid_r <= 1'b0;  wb_data_r <= 80'd0;  wb_sec_r <= 1'b0;  wb_last_r <= 1'b0;
      wb_cc_r <= 4'd0;  wb_flags_r <= 6'd0;  wb_to_r <= 1'b0;
      busy_r <= 1'b0;  req_ready_r <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            op_r <= req_op;  rmode_r <= req_rmode;  a_r <= req_a;  b_r <= req_b;
            en_r <= 1'b1;  wd_cnt_r <= 16'd0;  has_sec_r <= 1'b0;
            wb_data_r <= 80'd0;  wb_sec_r <= 1'b0;  wb_last_r <= 1'b0;
            wb_cc_r <= 4'd0;  wb_flags_r <= 6'd0;  wb_to_r <= 1'b0;
          end
        end
        ST_ISSUE: en_r <= 1'b0;
        ST_WAIT: begin
          if (done_take_s) begin
            wb_data_r  <= fmt_primary(op_r, au_result, au_int16_out, au_int32_out,
                                      au_fp32_out, au_fp64_out);
            sec_data_r <= au_result_secondary;
            has_sec_r  <= au_has_secondary;
            wb_cc_r    <= au_cc;
            wb_flags_r <= au_flags;
            wb_last_r  <= ~au_has_secondary;
            wb_valid_r <= 1'b1;
          end else if (to_take_s) begin
            wb_data_r  <= 80'd0;
            has_sec_r  <= 1'b0;
            wb_flags_r <= 6'b000001;
            wb_to_r    <= 1'b1;
            wb_last_r  <= 1'b1;
            wb_valid_r <= 1'b1;
          end else begin
            wd_cnt_r <= wd_cnt_r + 16'd1;
          end
        end
        ST_WB_PRI: begin
          if (wb_ready) begin
            if (has_sec_r) begin
              wb_data_r <= sec_data_r;
              wb_sec_r  <= 1'b1;
              wb_last_r <= 1'b1;
            end else begin
              wb_valid_r <= 1'b0;
            end
          end
        end
        ST_WB_SEC: begin
          if (wb_ready) wb_valid_r <= 1'b0;
        end
        default: wb_valid_r <= 1'b0;
      endcase
      busy_r      <= (state_nxt_s != ST_IDLE);
      req_ready_r <= (state_nxt_s == ST_IDLE);
    end
  end

  // Enable is masked by reset so the unit is never started while reset is held.
  assign au_enable        = en_r & ~reset;
  assign au_operation     = op_r;
  assign au_rounding_mode = rmode_r;
  assign au_operand_a     = a_r;
  assign au_operand_b     = b_r;
  assign au_int16_in      = a_r[15:0];
  assign au_int32_in      = a_r[31:0];
  assign au_fp32_in       = a_r[31:0];
  assign au_fp64_in       = a_r[63:0];
  assign wb_valid         = wb_valid_r;
  assign wb_data          = wb_data_r;
  assign wb_secondary     = wb_sec_r;
  assign wb_last          = wb_last_r;
  assign wb_cc            = wb_cc_r;
  assign wb_flags         = wb_flags_r;
  assign wb_timeout       = wb_to_r;
  assign busy             = busy_r;
  assign req_ready        = req_ready_r;

`ifdef FPU_SEQ_PERF_EN
  logic [CNT_W-1:0] perf_ops_r, perf_busy_r, perf_to_r;

  // Free-running, wrapping performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_ops_r  <= '0;
      perf_busy_r <= '0;
      perf_to_r   <= '0;
    end else begin
      if (state_r != ST_IDLE) perf_busy_r <= perf_busy_r + CNT_W'(1);
      if (wb_valid_r && wb_ready && wb_last_r) perf_ops_r <= perf_ops_r + CNT_W'(1);
      if (to_take_s) perf_to_r <= perf_to_r + CNT_W'(1);
    end
  end

  assign perf_ops         = perf_ops_r;
  assign perf_busy_cycles = perf_busy_r;
  assign perf_timeouts    = perf_to_r;
`endif

endmodule

// File: tb/tb_fpu_arith_sequencer.sv
// Scoreboard bench for fpu_arith_sequencer: stimulus pushes expected beats, a negedge monitor pops and checks.
module tb_fpu_arith_sequencer;
  logic clk = 1'b0;
  logic reset;
  logic req_valid, req_ready;
  logic [3:0] req_op;
  logic [1:0] req_rmode;
  logic [79:0] req_a, req_b;
  logic [3:0] au_operation;
  logic au_enable;
  logic [1:0] au_rounding_mode;
  logic [79:0] au_operand_a, au_operand_b;
  logic [15:0] au_int16_in;
  logic [31:0] au_int32_in, au_fp32_in;
  logic [63:0] au_fp64_in;
  logic [79:0] au_result, au_result_secondary;
  logic au_has_secondary;
  logic [15:0] au_int16_out;
  logic [31:0] au_int32_out, au_fp32_out;
  logic [63:0] au_fp64_out;
  logic au_done;
  logic [3:0] au_cc;
  logic [5:0] au_flags;
  logic wb_valid, wb_ready;
  logic [79:0] wb_data;
  logic wb_secondary, wb_last, wb_timeout, busy;
  logic [3:0] wb_cc;
  logic [5:0] wb_flags;

  always #5 clk = ~clk;

  fpu_arith_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rmode(req_rmode),
    .req_a(req_a), .req_b(req_b),
    .au_operation(au_operation), .au_enable(au_enable), .au_rounding_mode(au_rounding_mode),
    .au_operand_a(au_operand_a), .au_operand_b(au_operand_b),
    .au_int16_in(au_int16_in), .au_int32_in(au_int32_in), .au_fp32_in(au_fp32_in),
    .au_fp64_in(au_fp64_in),
    .au_result(au_result), .au_result_secondary(au_result_secondary),
    .au_has_secondary(au_has_secondary),
    .au_int16_out(au_int16_out), .au_int32_out(au_int32_out), .au_fp32_out(au_fp32_out),
    .au_fp64_out(au_fp64_out), .au_done(au_done), .au_cc(au_cc), .au_flags(au_flags),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_secondary(wb_secondary),
    .wb_last(wb_last), .wb_cc(wb_cc), .wb_flags(wb_flags), .wb_timeout(wb_timeout), .busy(busy)
  );

  typedef struct {
    logic [79:0] data;
    logic        sec;
    logic        last;
    logic [3:0]  cc;
    logic [5:0]  flags;
    logic        to;
  } beat_t;

  beat_t q[$];
  beat_t mon_e;
  int tests = 0;
  int fails = 0;
  int en_cnt = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [79:0] d, input logic s, input logic l,
                      input logic [3:0] c, input logic [5:0] f, input logic t);
    beat_t b;
    b.data = d; b.sec = s; b.last = l; b.cc = c; b.flags = f; b.to = t;
    q.push_back(b);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a request and returns just after the edge where the sequencer enters ISSUE.
  task automatic issue(input logic [3:0] op, input logic [1:0] rm, input logic [79:0] a,
                       input logic [79:0] b);
    logic got;
    got = 1'b0;
    req_op = op; req_rmode = rm; req_a = a; req_b = b; req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (au_enable === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
    check("accept_enable", 80'(got), 80'd1);
    check("au_operation", 80'(au_operation), 80'(op));
    check("au_rmode", 80'(au_rounding_mode), 80'(rm));
    check("au_operand_a", au_operand_a, a);
    check("au_operand_b", au_operand_b, b);
  endtask

  // Raises au_done for one cycle after d more edges, then checks the beat appears.
  task automatic done_after(input int d);
    repeat (d) step();
    au_done = 1'b1;
    step();
    au_done = 1'b0;
    check("wb_valid_after_done", 80'(wb_valid), 80'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30; i++) begin
      if (req_ready === 1'b1) break;
      step();
    end
    check("return_idle", 80'(req_ready), 80'd1);
  endtask

  // Enable pulse counter.
  always @(negedge clk) if (au_enable === 1'b1) en_cnt++;

  // Scoreboard monitor: every valid cycle must match the head beat; pop on handshake.
  always @(negedge clk) begin
    if (reset === 1'b0 && wb_valid === 1'b1) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got data %h, expected no beat", wb_data);
      end else begin
        mon_e = q[0];
        check("wb_data", wb_data, mon_e.data);
        check("wb_secondary", 80'(wb_secondary), 80'(mon_e.sec));
        check("wb_last", 80'(wb_last), 80'(mon_e.last));
        check("wb_cc", 80'(wb_cc), 80'(mon_e.cc));
        check("wb_flags", 80'(wb_flags), 80'(mon_e.flags));
        check("wb_timeout", 80'(wb_timeout), 80'(mon_e.to));
        if (wb_ready === 1'b1) void'(q.pop_front());
      end
    end
  end

  logic [3:0]  v_op   [4];
  logic [79:0] v_data [4];

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_rmode = 2'd0;
    req_a = 80'd0; req_b = 80'd0; au_result = 80'd0; au_result_secondary = 80'd0;
    au_has_secondary = 1'b0; au_int16_out = 16'd0; au_int32_out = 32'd0;
    au_fp32_out = 32'd0; au_fp64_out = 64'd0; au_done = 1'b0; au_cc = 4'd0;
    au_flags = 6'd0; wb_ready = 1'b1;
    step(); step();
    check("rst_req_ready", 80'(req_ready), 80'd1);
    check("rst_busy", 80'(busy), 80'd0);
    check("rst_wb_valid", 80'(wb_valid), 80'd0);
    check("rst_au_enable", 80'(au_enable), 80'd0);
    check("rst_wb_data", wb_data, 80'd0);
    check("rst_au_op", 80'(au_operation), 80'd0);
    reset = 1'b0;
    step();

    // 1.0 + 2.0 = 3.0, done three cycles after enable.
    au_result = 80'h4000C000000000000000; au_cc = 4'b0100;
    push(80'h4000C000000000000000, 1'b0, 1'b1, 4'b0100, 6'd0, 1'b0);
    issue(4'd0, 2'b01, 80'h3FFF8000000000000000, 80'h40008000000000000000);
    check("busy_in_issue", 80'(busy), 80'd1);
    check("ready_in_issue", 80'(req_ready), 80'd0);
    done_after(3);
    step();
    check("ready_after_last", 80'(req_ready), 80'd1);
    check("valid_after_last", 80'(wb_valid), 80'd0);

    // FSINCOS: two beats with wb_ready withheld.
    au_result = 80'h1111; au_result_secondary = 80'h2222; au_has_secondary = 1'b1;
    au_cc = 4'b0001; au_flags = 6'b100000;
    push(80'h1111, 1'b0, 1'b0, 4'b0001, 6'b100000, 1'b0);
    push(80'h2222, 1'b1, 1'b1, 4'b0001, 6'b100000, 1'b0);
    wb_ready = 1'b0;
    issue(4'd15, 2'b00, 80'h3FFE8000000000000000, 80'd0);
    done_after(1);
    repeat (4) step();
    wb_ready = 1'b1;
    wait_idle();
    au_has_secondary = 1'b0;

    // Conversion ops return zero-extended raw patterns.
    au_result = 80'hDEADBEEFDEADBEEFDEAD; au_cc = 4'b0000; au_flags = 6'b100000;
    au_int16_out = 16'hFFFE; au_int32_out = 32'h80000001;
    au_fp32_out = 32'hBF800000; au_fp64_out = 64'hC000000000000001;
    v_op[0] = 4'd6;  v_data[0] = 80'h0000_0000_0000_0000_FFFE;
    v_op[1] = 4'd7;  v_data[1] = 80'h0000_0000_0000_8000_0001;
    v_op[2] = 4'd10; v_data[2] = 80'h0000_0000_0000_BF80_0000;
    v_op[3] = 4'd11; v_data[3] = 80'h0000_C000_0000_0000_0001;
    for (int k = 0; k < 4; k++) begin
      push(v_data[k], 1'b0, 1'b1, 4'b0000, 6'b100000, 1'b0);
      issue(v_op[k], 2'b11, 80'h1234_5678_9ABC_DEF0_1357, 80'd0);
      check("au_int16_in", 80'(au_int16_in), 80'h1357);
      check("au_int32_in", 80'(au_int32_in), 80'hDEF0_1357);
      check("au_fp32_in", 80'(au_fp32_in), 80'hDEF0_1357);
      check("au_fp64_in", 80'(au_fp64_in), 80'h5678_9ABC_DEF0_1357);
      done_after(2);
      wait_idle();
    end

    // Watchdog: no done, TIMEOUT_CYCLES=8 -> beat 9 cycles after ISSUE.
    au_has_secondary = 1'b1; au_cc = 4'b0000; au_flags = 6'b111111;
    push(80'd0, 1'b0, 1'b1, 4'b0000, 6'b000001, 1'b1);
    issue(4'd12, 2'b00, 80'h3FFF8000000000000000, 80'd0);
    repeat (8) step();
    check("to_not_early", 80'(wb_valid), 80'd0);
    step();
    check("to_on_time", 80'(wb_valid), 80'd1);
    wait_idle();
    au_has_secondary = 1'b0;

    // Reset during WAIT discards the operation.
    au_flags = 6'd0; au_result = 80'h4001A000000000000000;
    issue(4'd2, 2'b00, 80'h1, 80'h2);
    step();
    reset = 1'b1;
    step();
    check("mid_rst_busy", 80'(busy), 80'd0);
    check("mid_rst_ready", 80'(req_ready), 80'd1);
    check("mid_rst_valid", 80'(wb_valid), 80'd0);
    check("mid_rst_enable", 80'(au_enable), 80'd0);
    reset = 1'b0;
    step();
    push(80'h4001A000000000000000, 1'b0, 1'b1, 4'b0000, 6'd0, 1'b0);
    issue(4'd2, 2'b10, 80'h3, 80'h4);
    done_after(2);
    wait_idle();

    // Divide: done during ISSUE is ignored; later done carries zero_divide.
    au_result = 80'h7FFF8000000000000000; au_cc = 4'b0010; au_flags = 6'b000001;
    push(80'h7FFF8000000000000000, 1'b0, 1'b1, 4'b0010, 6'b000100, 1'b0);
    issue(4'd3, 2'b00, 80'h3FFF8000000000000000, 80'd0);
    au_done = 1'b1;
    step();
    au_done = 1'b0;
    au_flags = 6'b000100;
    step();
    check("issue_done_ignored", 80'(wb_valid), 80'd0);
    done_after(2);
    check("zero_divide_bit", 80'(wb_flags[2]), 80'd1);
    wait_idle();

    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    check("scoreboard_drained", 80'(q.size()), 80'd0);
    check("enable_pulses", 80'(en_cnt), 80'd10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded 100000 time units");
    $fatal(1, "timeout");
  end
endmodule
